// File: rtl/rv32i_pkg.sv
// Shared RV32I register-file types and the write-port grant-source encoding.
package rv32i_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    typedef enum logic [2:0] {
        GNT_NONE       = 3'd0,
        GNT_WB         = 3'd1,
        GNT_DBG_FORCED = 3'd2,
        GNT_LD         = 3'd3,
        GNT_DBG        = 3'd4
    } gnt_src_e;

    // One register-file write: destination and data (37 bits).
    typedef struct packed {
        reg_addr_t rd;
        xlen_t     data;
    } rf_wr_t;

    // x0 is hardwired to zero, so writes to it are consumed but never committed.
    function automatic logic is_x0(input reg_addr_t rd);
        return rd == '0;
    endfunction

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Bundles the WB, LD, DBG, hazard-check and register-file write-port signals of the scheduler.
interface regfile_write_scheduler_if;
    import rv32i_pkg::*;

    logic                wb_valid;
    reg_addr_t           wb_rd;
    xlen_t               wb_data;
    logic                ld_issue_valid;
    reg_addr_t           ld_issue_rd;
    logic                ld_valid;
    reg_addr_t           ld_rd;
    xlen_t               ld_data;
    logic                ld_ready;
    logic                dbg_valid;
    reg_addr_t           dbg_rd;
    xlen_t               dbg_data;
    logic                dbg_ready;
    reg_addr_t           src1_reg;
    reg_addr_t           src2_reg;
    logic                raw_hazard;
    logic                core_stall;
    logic [NUM_REGS-1:0] pending;
    logic                rf_we;
    reg_addr_t           rf_rd;
    xlen_t               rf_wdata;

    // Core / memory / debug side.
    modport master (
        output wb_valid, wb_rd, wb_data,
        output ld_issue_valid, ld_issue_rd,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready,
        output dbg_valid, dbg_rd, dbg_data,
        input  dbg_ready,
        output src1_reg, src2_reg,
        input  raw_hazard, core_stall, pending,
        input  rf_we, rf_rd, rf_wdata
    );

    // Scheduler side.
    modport slave (
        input  wb_valid, wb_rd, wb_data,
        input  ld_issue_valid, ld_issue_rd,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready,
        input  dbg_valid, dbg_rd, dbg_data,
        output dbg_ready,
        input  src1_reg, src2_reg,
        output raw_hazard, core_stall, pending,
        output rf_we, rf_rd, rf_wdata
    );

endinterface

// File: rtl/regfile_ld_fifo.sv
// Synchronous load-return FIFO holding {rd,data} entries; head is visible without popping.
module regfile_ld_fifo
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  rf_wr_t push_data,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output rf_wr_t head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    rf_wr_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the single register-file write port between WB, buffered LD returns and DBG,
// and tracks outstanding loads for RAW hazard detection.
module regfile_write_scheduler
    import rv32i_pkg::*;
#(
    parameter int unsigned LD_DEPTH     = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input logic                      clk,
    input logic                      rst,
    regfile_write_scheduler_if.slave bus
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_cnt_d;
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    gnt_src_e gnt;
    rf_wr_t   ld_in;
    rf_wr_t   ld_head;
    rf_wr_t   wr_sel;
    logic     fifo_full;
    logic     fifo_empty;
    logic     ld_ready;
    logic     ld_push;
    logic     ld_pop;
    logic     dbg_ready;
    logic     dbg_forced;

    assign ld_in.rd   = bus.ld_rd;
    assign ld_in.data = bus.ld_data;

    regfile_ld_fifo #(
        .DEPTH (LD_DEPTH)
    ) u_ld_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ld_push),
        .push_data (ld_in),
        .pop       (ld_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (ld_head)
    );

    // Fixed-priority grant; a starving DBG request jumps ahead of the LD buffer.
    always_comb begin
        gnt        = GNT_NONE;
        wr_sel     = ld_head;
        dbg_forced = bus.dbg_valid && (starve_cnt >= STARVE_W'(STARVE_LIMIT));
        if (rst) begin
            if (bus.wb_valid) begin
                gnt = GNT_WB;
            end else if (dbg_forced) begin
                gnt = GNT_DBG_FORCED;
            end else if (!fifo_empty) begin
                gnt = GNT_LD;
            end else if (bus.dbg_valid) begin
                gnt = GNT_DBG;
            end
        end
        case (gnt)
            GNT_WB: begin
                wr_sel.rd   = bus.wb_rd;
                wr_sel.data = bus.wb_data;
            end
            GNT_DBG_FORCED, GNT_DBG: begin
                wr_sel.rd   = bus.dbg_rd;
                wr_sel.data = bus.dbg_data;
            end
            default: wr_sel = ld_head;
        endcase
    end

    assign ld_ready  = rst && !fifo_full;
    assign ld_push   = bus.ld_valid && ld_ready;
    assign ld_pop    = (gnt == GNT_LD);
    assign dbg_ready = (gnt == GNT_DBG) || (gnt == GNT_DBG_FORCED);

    assign bus.ld_ready   = ld_ready;
    assign bus.dbg_ready  = dbg_ready;
    assign bus.rf_we      = (gnt != GNT_NONE) && !is_x0(wr_sel.rd);
    assign bus.rf_rd      = wr_sel.rd;
    assign bus.rf_wdata   = wr_sel.data;
    assign bus.core_stall = rst && (fifo_full || dbg_forced);
    assign bus.raw_hazard = rst && (pending_q[bus.src1_reg] || pending_q[bus.src2_reg]);
    assign bus.pending    = pending_q;

    // Next-state for the starvation counter and the pending-load scoreboard.
    always_comb begin
        starve_cnt_d = starve_cnt;
        pending_d    = pending_q;
        if (!bus.dbg_valid || dbg_ready) begin
            starve_cnt_d = '0;
        end else if (starve_cnt < STARVE_W'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt + STARVE_W'(1);
        end
        if (ld_pop) begin
            pending_d[ld_head.rd] = 1'b0;
        end
        // Applied after the clear so a same-register issue wins.
        if (bus.ld_issue_valid) begin
            pending_d[bus.ld_issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
            pending_q  <= '0;
        end else begin
            starve_cnt <= starve_cnt_d;
            pending_q  <= pending_d;
        end
    end

    // Core protocol checks.
    ap_no_wb_after_stall : assert property (
        @(posedge clk) disable iff (!rst)
        bus.core_stall |=> !bus.wb_valid
    );

    ap_issue_not_pending : assert property (
        @(posedge clk) disable iff (!rst)
        (bus.ld_issue_valid && !is_x0(bus.ld_issue_rd)) |->
            (!pending_q[bus.ld_issue_rd] || (ld_pop && (ld_head.rd == bus.ld_issue_rd)))
    );

    ap_wb_not_pending : assert property (
        @(posedge clk) disable iff (!rst)
        (bus.wb_valid && !is_x0(bus.wb_rd)) |-> !pending_q[bus.wb_rd]
    );

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed plus randomized bench for regfile_write_scheduler against a queue-based reference model.
module tb_regfile_write_scheduler;
    import rv32i_pkg::*;

    localparam int LD_DEPTH     = 4;
    localparam int STARVE_LIMIT = 8;

    localparam int W_NONE = 0;
    localparam int W_WB   = 1;
    localparam int W_DBG  = 2;
    localparam int W_LD   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_write_scheduler_if bus ();

    regfile_write_scheduler #(
        .LD_DEPTH     (LD_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: buffered loads as a queue, pending loads as a bit set.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    bit [31:0]   m_pend        = '0;
    int          m_starve      = 0;
    int          m_win         = W_NONE;
    bit          m_stall_prev  = 1'b0;
    bit          m_dbg_granted = 1'b0;
    bit          m_ld_accepted = 1'b0;

    function automatic int pick_winner();
        if (!rst)                                        return W_NONE;
        if (bus.wb_valid)                                return W_WB;
        if (bus.dbg_valid && m_starve >= STARVE_LIMIT)   return W_DBG;
        if (mq.size() != 0)                              return W_LD;
        if (bus.dbg_valid)                               return W_DBG;
        return W_NONE;
    endfunction

    // Compare all outputs against the model, mid-cycle.
    task automatic sample();
        int          w;
        bit          full;
        bit          forced;
        logic [4:0]  erd;
        logic [31:0] edata;
        @(negedge clk);
        w      = pick_winner();
        full   = (mq.size() == LD_DEPTH);
        forced = bus.dbg_valid && (m_starve >= STARVE_LIMIT);
        erd    = '0;
        edata  = '0;
        if (w == W_WB) begin
            erd = bus.wb_rd;  edata = bus.wb_data;
        end else if (w == W_DBG) begin
            erd = bus.dbg_rd; edata = bus.dbg_data;
        end else if (w == W_LD) begin
            erd = mq[0].rd;   edata = mq[0].data;
        end
        check("rf_we", 32'(bus.rf_we), 32'((w != W_NONE) && (erd != 5'd0)));
        if (w != W_NONE) begin
            check("rf_rd", 32'(bus.rf_rd), 32'(erd));
            check("rf_wdata", bus.rf_wdata, edata);
        end
        check("ld_ready", 32'(bus.ld_ready), 32'(rst && !full));
        check("dbg_ready", 32'(bus.dbg_ready), 32'(w == W_DBG));
        check("core_stall", 32'(bus.core_stall), 32'(rst && (full || forced)));
        check("raw_hazard", 32'(bus.raw_hazard),
              32'(rst && (m_pend[bus.src1_reg] || m_pend[bus.src2_reg])));
        check("pending", bus.pending, m_pend);
        m_win = w;
    endtask

    // Apply the clock edge to the model using the inputs of the cycle that just ended.
    task automatic advance();
        bit         full;
        ent_t       e;
        logic [4:0] pop_rd;
        full = (mq.size() == LD_DEPTH);
        @(posedge clk);
        m_dbg_granted = (m_win == W_DBG);
        m_ld_accepted = rst && bus.ld_valid && !full;
        m_stall_prev  = rst && (full || (bus.dbg_valid && m_starve >= STARVE_LIMIT));
        if (!rst) begin
            mq.delete();
            m_pend   = '0;
            m_starve = 0;
        end else begin
            if (m_win == W_LD) begin
                pop_rd = mq[0].rd;
                e = mq.pop_front();
                m_pend[pop_rd] = 1'b0;
            end
            if (m_ld_accepted) begin
                e.rd   = bus.ld_rd;
                e.data = bus.ld_data;
                mq.push_back(e);
            end
            if (bus.ld_issue_valid) m_pend[bus.ld_issue_rd] = 1'b1;
            m_pend[0] = 1'b0;
            if (!bus.dbg_valid || m_dbg_granted) m_starve = 0;
            else if (m_starve < STARVE_LIMIT)    m_starve++;
        end
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    task automatic idle();
        bus.wb_valid       = 1'b0;
        bus.wb_rd          = '0;
        bus.wb_data        = '0;
        bus.ld_issue_valid = 1'b0;
        bus.ld_issue_rd    = '0;
        bus.ld_valid       = 1'b0;
        bus.ld_rd          = '0;
        bus.ld_data        = '0;
        bus.dbg_valid      = 1'b0;
        bus.dbg_rd         = '0;
        bus.dbg_data       = '0;
        bus.src1_reg       = '0;
        bus.src2_reg       = '0;
    endtask

    function automatic logic [4:0] some_pending();
        for (int i = 1; i < 32; i++) begin
            if (m_pend[i]) return 5'(i);
        end
        return 5'($urandom);
    endfunction

    // Random legal stimulus: honours stall, hold-until-accepted and no double issue.
    task automatic gen();
        rst = ($urandom_range(0, 299) != 0);
        bus.wb_valid = !m_stall_prev && ($urandom_range(0, 2) == 0);
        bus.wb_rd    = 5'($urandom);
        if (m_pend[bus.wb_rd]) bus.wb_rd = '0;
        bus.wb_data  = $urandom;
        bus.ld_issue_rd    = 5'($urandom);
        bus.ld_issue_valid = ($urandom_range(0, 3) == 0) && !m_pend[bus.ld_issue_rd];
        if (!(bus.ld_valid && !m_ld_accepted)) begin
            bus.ld_valid = 1'($urandom_range(0, 1));
            bus.ld_rd    = ($urandom_range(0, 1) == 1) ? some_pending() : 5'($urandom);
            bus.ld_data  = $urandom;
        end
        if (!(bus.dbg_valid && !m_dbg_granted)) begin
            bus.dbg_valid = ($urandom_range(0, 3) == 0);
            bus.dbg_rd    = 5'($urandom);
            bus.dbg_data  = $urandom;
        end
        bus.src1_reg = 5'($urandom);
        bus.src2_reg = 5'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with every request asserted.
        idle();
        rst = 1'b0;
        bus.wb_valid = 1'b1;  bus.wb_rd = 5'd1;  bus.wb_data = 32'h1111_1111;
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd3;
        bus.ld_valid = 1'b1;  bus.ld_rd = 5'd2;  bus.ld_data = 32'h2222_2222;
        bus.dbg_valid = 1'b1; bus.dbg_rd = 5'd4; bus.dbg_data = 32'h4444_4444;
        @(posedge clk); #1;
        repeat (2) begin
            sample();
            check("rst_rf_we", 32'(bus.rf_we), 32'd0);
            check("rst_pending", bus.pending, 32'd0);
            advance();
        end
        rst = 1'b1;
        idle();
        sample();
        check("rel_ld_ready", 32'(bus.ld_ready), 32'd1);
        advance();

        // Load flow for x5.
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd5;
        cyc();
        bus.ld_issue_valid = 1'b0; bus.src1_reg = 5'd5;
        sample();
        check("issue_pend5", 32'(bus.pending[5]), 32'd1);
        check("issue_hazard", 32'(bus.raw_hazard), 32'd1);
        advance();
        bus.src1_reg = '0;
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd5; bus.ld_data = 32'hDEAD_BEEF;
        cyc();
        bus.ld_valid = 1'b0;
        sample();
        check("ld_we", 32'(bus.rf_we), 32'd1);
        check("ld_rd", 32'(bus.rf_rd), 32'd5);
        check("ld_data", bus.rf_wdata, 32'hDEAD_BEEF);
        advance();
        sample();
        check("ld_pend5_clr", 32'(bus.pending[5]), 32'd0);
        advance();

        // WB every cycle while four loads fill the buffer, then drain in order.
        for (int i = 0; i < 4; i++) begin
            bus.wb_valid = 1'b1; bus.wb_rd = 5'(i + 1); bus.wb_data = $urandom;
            bus.ld_valid = 1'b1; bus.ld_rd = 5'(10 + i); bus.ld_data = 32'hA000_0000 + 32'(i);
            cyc();
        end
        bus.ld_valid = 1'b0;
        sample();
        check("full_ld_ready", 32'(bus.ld_ready), 32'd0);
        check("full_stall", 32'(bus.core_stall), 32'd1);
        advance();
        bus.wb_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("drain_rd", 32'(bus.rf_rd), 32'(10 + i));
            check("drain_data", bus.rf_wdata, 32'hA000_0000 + 32'(i));
            advance();
        end

        // DBG starves behind a continuous LD stream until forced through.
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd12; bus.ld_data = $urandom;
        cyc();
        bus.dbg_valid = 1'b1; bus.dbg_rd = 5'd7; bus.dbg_data = 32'h0000_1234;
        for (int k = 0; k < STARVE_LIMIT; k++) begin
            bus.ld_data = $urandom;
            sample();
            check("starve_wait", 32'(bus.dbg_ready), 32'd0);
            advance();
        end
        bus.ld_data = $urandom;
        sample();
        check("starve_grant", 32'(bus.dbg_ready), 32'd1);
        check("starve_stall", 32'(bus.core_stall), 32'd1);
        check("starve_rd", 32'(bus.rf_rd), 32'd7);
        check("starve_data", bus.rf_wdata, 32'h0000_1234);
        advance();
        bus.dbg_valid = 1'b0; bus.ld_data = $urandom;
        sample();
        check("starve_unstall", 32'(bus.core_stall), 32'd0);
        advance();
        bus.ld_valid = 1'b0;
        repeat (3) cyc();

        // x0 writes are consumed without a register-file write.
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.ld_data = 32'hBAD0_0000;
        cyc();
        bus.ld_valid = 1'b0;
        sample();
        check("x0_ld_we", 32'(bus.rf_we), 32'd0);
        advance();
        bus.dbg_valid = 1'b1; bus.dbg_rd = 5'd0; bus.dbg_data = 32'hBAD0_0001;
        sample();
        check("x0_dbg_ready", 32'(bus.dbg_ready), 32'd1);
        check("x0_dbg_we", 32'(bus.rf_we), 32'd0);
        advance();
        bus.dbg_valid = 1'b0;
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd0;
        cyc();
        bus.ld_issue_valid = 1'b0;
        sample();
        check("x0_issue_pend", bus.pending, 32'd0);
        advance();

        // Re-issue of x9 in the cycle its earlier load commits keeps it pending.
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd9;
        cyc();
        bus.ld_issue_valid = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd9; bus.ld_data = 32'h9999_0001;
        cyc();
        bus.ld_valid = 1'b0;
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd9;
        cyc();
        bus.ld_issue_valid = 1'b0;
        sample();
        check("same_cycle_pend9", 32'(bus.pending[9]), 32'd1);
        advance();
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd9; bus.ld_data = 32'h9999_0002;
        cyc();
        bus.ld_valid = 1'b0;
        repeat (2) cyc();

        // Reset in mid-operation drops buffered loads and scoreboard bits.
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd20;
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd21; bus.ld_data = $urandom;
        cyc();
        bus.ld_issue_valid = 1'b0;
        bus.ld_rd = 5'd22; bus.ld_data = $urandom;
        cyc();
        bus.ld_valid = 1'b0;
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        sample();
        check("midrst_pend", bus.pending, 32'd0);
        check("midrst_we", 32'(bus.rf_we), 32'd0);
        advance();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            gen();
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Shares the register file's single write port between three sources: core writeback (WB), load-return (LD), and debug (DBG).
- Buffers load returns in a small FIFO and keeps a per-register pending-load scoreboard so the core can stall on RAW hazards.
- Asserts a core stall when the LD buffer is full or DBG is starving.
- Sits between the core datapath, the data-memory load path and the debug module, and drives the register file's write port.

Parameters:
- LD_DEPTH, 4, load-return FIFO entries; power of two, 2..16.
- STARVE_LIMIT, 8, consecutive cycles a DBG request may wait before it preempts LD and forces a core stall.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- wb_valid  in  1  core writeback request; cannot be back-pressured.
- wb_rd  in  5  WB destination register.
- wb_data  in  32  WB write data.
- ld_issue_valid  in  1  core issued a load; marks ld_issue_rd pending.
- ld_issue_rd  in  5  destination of the issued load.
- ld_valid  in  1  load data return valid.
- ld_rd  in  5  load-return destination register.
- ld_data  in  32  load-return data.
- ld_ready  out  1  LD FIFO can accept an entry.
- dbg_valid  in  1  debug write request.
- dbg_rd  in  5  DBG destination register.
- dbg_data  in  32  DBG write data.
- dbg_ready  out  1  DBG write granted this cycle.
- src1_reg  in  5  core source register 1, for hazard check.
- src2_reg  in  5  core source register 2, for hazard check.
- raw_hazard  out  1  src1 or src2 has a pending load.
- core_stall  out  1  core must not assert wb_valid next cycle.
- pending  out  32  scoreboard; bit n = load to xn outstanding.
- rf_we  out  1  register file write enable.
- rf_rd  out  5  register file write address.
- rf_wdata  out  32  register file write data.

Behaviour:
- Reset (rst low at a clock edge): FIFO empty, pending=0, starve_cnt=0.
  - While rst is low: rf_we, ld_ready, dbg_ready, core_stall and raw_hazard are forced to 0.
  - A reset in mid-operation discards buffered loads and scoreboard bits.
- Grant priority each cycle, combinational, one winner:
  1. WB.
  2. DBG if starve_cnt >= STARVE_LIMIT.
  3. LD FIFO head.
  4. DBG.
- Winner drives rf_rd and rf_wdata. rf_we=1 unless the winner's rd=0: an x0 write is consumed (dequeue / dbg_ready) but rf_we=0.
- No grant: rf_we=0; rf_rd and rf_wdata hold the FIFO head values (don't-care).
- LD FIFO:
  - ld_ready = !full; push on ld_valid && ld_ready.
  - Pop when LD is granted.
  - No bypass: minimum latency is 1 cycle from push to rf write.
  - Push and pop in the same cycle keep the count unchanged.
  - Pointers wrap modulo LD_DEPTH.
  - ld_valid while full: entry not accepted; the source must hold it.
- DBG handshake: dbg_ready=1 only in the cycle DBG is granted. The source holds valid/rd/data stable until ready.
- starve_cnt (saturating at STARVE_LIMIT):
  - +1 each cycle dbg_valid && !dbg_ready.
  - Cleared on dbg_ready or !dbg_valid.
- core_stall = FIFO full OR (dbg_valid AND starve_cnt >= STARVE_LIMIT). This frees the write slot for the following cycle.
- wb_valid asserted the cycle after core_stall is a protocol error (assertion). WB still wins the grant.
- Scoreboard (registered):
  - ld_issue_valid && ld_issue_rd!=0 sets pending[rd].
  - An LD write commit clears pending[ld rd].
  - Same rd set and clear in one cycle: set wins.
  - pending[0] is constantly 0.
  - Issue to an already-pending rd is illegal (assertion); the core prevents it via raw_hazard.
- raw_hazard = pending[src1_reg] | pending[src2_reg], combinational from the registered pending vector.
- WB to a register with pending set does not clear the bit (assertion flags it as a core bug).

Decomposition:
- Shared package (rv32i_pkg):
  - REG_ADDR_W=5, XLEN=32, NUM_REGS=32.
  - Grant-source encoding GNT_NONE/WB/DBG_FORCED/LD/DBG.
- Sub-module regfile_ld_fifo: parameterised synchronous FIFO (push/pop/full/empty/head), 37-bit entries {rd,data}.
- Arbitration, starvation counter and scoreboard stay in the top.

Test Plan:
- Reset: hold rst=0 with all valids=1 -> rf_we=0, ld_ready=0, dbg_ready=0, pending=0. Release -> FIFO empty, ld_ready=1.
- Load flow:
  - Issue load x5 -> pending[5]=1 next cycle; src1_reg=5 -> raw_hazard=1.
  - ld_valid x5=0xDEADBEEF -> rf_we=1, rf_rd=5 the next cycle; pending[5]=0 the cycle after.
- Contention: wb_valid every cycle plus 4 loads returned -> ld_ready=0 and core_stall=1 after the 4th push. Drop wb_valid -> FIFO drains at 1 write/cycle in order.
- Starvation: dbg_valid x7=0x1234 with a continuous LD stream -> after 8 waiting cycles core_stall=1 and DBG granted ahead of LD; starve_cnt returns to 0.
- x0 handling:
  - LD to x0 and DBG to x0 -> dequeue/dbg_ready occur, rf_we=0.
  - ld_issue_rd=0 -> pending unchanged.
- Same-cycle events: issue x9 while an earlier x9 load commits -> pending[9] stays 1. Push and pop at count 2 -> count stays 2.
